// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module   : la_pkg
// Brief    : HUB command codes, status bit indices and readout FSM states.
// Revision : 1.0
// ============================================================================
package la_pkg;

  localparam logic [7:0] CMD_NOP                = 8'h00;
  localparam logic [7:0] CMD_ARM_CAPTURE        = 8'h01;
  localparam logic [7:0] CMD_ABORT_CAPTURE      = 8'h02;
  localparam logic [7:0] CMD_READ_STATUS        = 8'h03;
  localparam logic [7:0] CMD_READ_CAPTURE_COUNT = 8'h04;
  localparam logic [7:0] CMD_READ_TRACE_DATA    = 8'h05;
  localparam logic [7:0] CMD_READ_TRACE_REWIND  = 8'h06;
  localparam logic [7:0] CMD_READ_CHECKSUM      = 8'h07;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_DATA_VALID = 1;
  localparam int STAT_LAST       = 2;
  localparam int STAT_EMPTY      = 3;
  localparam int STAT_OVERRUN    = 4;
  localparam int STAT_NOT_READY  = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH0     = 3'd1,
    ST_FETCH1     = 3'd2,
    ST_LATCH      = 3'd3,
    ST_LATCH_LAST = 3'd4
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/trace_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : trace_addr_gen
// Brief    : Read pointer and remaining-packet counter for the circular
//            capture buffer; loads oldest-packet address on arm.
// Revision : 1.0
// ============================================================================
module trace_addr_gen
  import la_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] capture_end_addr,
  input  logic [31:0]           capture_count,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  rem_zero,
  output logic                  rem_one,
  output logic                  load_zero
);

  localparam logic [ADDR_WIDTH:0]   c_rem_full = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   c_rem_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH:0]   w_load_rem;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] w_load_ptr;

  // Any count bit at or above ADDR_WIDTH means the buffer wrapped: clamp to depth.
  assign w_load_rem = (|capture_count[31:ADDR_WIDTH]) ? c_rem_full
                                                       : {1'b0, capture_count[ADDR_WIDTH-1:0]};
  assign w_load_ptr = capture_end_addr - w_load_rem[ADDR_WIDTH-1:0] + c_ptr_one;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_remaining <= '0;
    end else if (arm) begin
      r_rd_ptr    <= w_load_ptr;
      r_remaining <= w_load_rem;
    end else if (step) begin
      r_rd_ptr    <= r_rd_ptr + c_ptr_one;
      r_remaining <= r_remaining - c_rem_one;
    end
  end

  assign rd_ptr    = r_rd_ptr;
  assign rem_zero  = (r_remaining == '0);
  assign rem_one   = (r_remaining == c_rem_one);
  assign load_zero = (capture_count == 32'd0);

endmodule
`default_nettype wire

// File: rtl/trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : trace_reader
// Brief    : Streams captured packets, oldest first, two per HUB command into
//            regOut0..7. Optional XOR checksum: TRACE_READER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module trace_reader
  import la_pkg::*;
#(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH          = 12
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [7:0]                     command,
  input  logic                           command_strobe,
  input  logic                           capture_done,
  input  logic [ADDR_WIDTH-1:0]          capture_end_addr,
  input  logic [31:0]                    capture_count,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
  output logic [7:0]                     regOut0,
  output logic [7:0]                     regOut1,
  output logic [7:0]                     regOut2,
  output logic [7:0]                     regOut3,
  output logic [7:0]                     regOut4,
  output logic [7:0]                     regOut5,
  output logic [7:0]                     regOut6,
  output logic [7:0]                     regOut7,
  output logic [7:0]                     status
);

  rd_state_e r_state;
  rd_state_e w_state_next;

  logic r_armed, r_data_valid, r_last, r_empty, r_overrun;
  logic [SAMPLE_PACKET_WIDTH-1:0] r_pkt0, r_pkt1;

  logic w_data_cmd, w_rewind_cmd, w_overrun_set, w_fetch, w_load_empty;
  logic w_arm, w_step, w_start, w_empty_hit;
  logic w_rem_zero, w_rem_one, w_load_zero;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;

`ifdef TRACE_READER_CHECKSUM_EN
  logic [SAMPLE_PACKET_WIDTH-1:0] r_csum;
  logic w_csum_cmd, w_csum_rd;
  assign w_csum_cmd = command_strobe && (command == CMD_READ_CHECKSUM) && capture_done;
`endif

  assign w_data_cmd    = command_strobe && (command == CMD_READ_TRACE_DATA) && capture_done;
  assign w_rewind_cmd  = command_strobe && (command == CMD_READ_TRACE_REWIND) && capture_done;
  assign w_overrun_set = w_data_cmd && (r_state != ST_IDLE);
  assign w_fetch       = (r_state == ST_FETCH0) || (r_state == ST_FETCH1);
  // On the arming strobe the stored count is stale; use the value being loaded.
  assign w_load_empty  = r_armed ? w_rem_zero : w_load_zero;

  trace_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk              (clk),
    .reset_n          (reset_n),
    .arm              (w_arm),
    .step             (w_step),
    .capture_end_addr (capture_end_addr),
    .capture_count    (capture_count),
    .rd_ptr           (w_rd_ptr),
    .rem_zero         (w_rem_zero),
    .rem_one          (w_rem_one),
    .load_zero        (w_load_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    w_step       = 1'b0;
    w_start      = 1'b0;
    w_empty_hit  = 1'b0;
`ifdef TRACE_READER_CHECKSUM_EN
    w_csum_rd    = 1'b0;
`endif
    if (!capture_done) begin
      w_state_next = ST_IDLE;
    end else if (w_rewind_cmd) begin
      w_arm        = 1'b1;
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_data_cmd) begin
            w_arm = !r_armed;
            if (w_load_empty) begin
              w_empty_hit = 1'b1;
            end else begin
              w_start      = 1'b1;
              w_state_next = ST_FETCH0;
            end
          end
`ifdef TRACE_READER_CHECKSUM_EN
          else if (w_csum_cmd) begin
            w_csum_rd = 1'b1;
          end
`endif
        end
        ST_FETCH0: begin
          w_step       = 1'b1;
          w_state_next = w_rem_one ? ST_LATCH_LAST : ST_FETCH1;
        end
        ST_FETCH1: begin
          w_step       = 1'b1;
          w_state_next = ST_LATCH;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed      <= 1'b0;
      r_data_valid <= 1'b0;
      r_last       <= 1'b0;
      r_empty      <= 1'b0;
      r_overrun    <= 1'b0;
      r_pkt0       <= '0;
      r_pkt1       <= '0;
    end else if (!capture_done) begin
      r_armed      <= 1'b0;
      r_data_valid <= 1'b0;
      r_last       <= 1'b0;
      r_empty      <= 1'b0;
    end else if (w_rewind_cmd) begin
      r_armed      <= 1'b1;
      r_data_valid <= 1'b0;
      r_last       <= 1'b0;
      r_empty      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_arm)         r_armed      <= 1'b1;
      if (w_overrun_set) r_overrun    <= 1'b1;
      if (w_start)       r_data_valid <= 1'b0;
      if (w_empty_hit) begin
        r_pkt0       <= '0;
        r_pkt1       <= '0;
        r_empty      <= 1'b1;
        r_data_valid <= 1'b1;
      end
`ifdef TRACE_READER_CHECKSUM_EN
      if (w_csum_rd) begin
        r_pkt0       <= r_csum;
        r_pkt1       <= '0;
        r_data_valid <= 1'b1;
      end
`endif
      case (r_state)
        ST_FETCH1: r_pkt0 <= mem_rd_data;
        ST_LATCH: begin
          r_pkt1       <= mem_rd_data;
          r_data_valid <= 1'b1;
          r_last       <= w_rem_zero;
        end
        ST_LATCH_LAST: begin
          r_pkt0       <= mem_rd_data;
          r_pkt1       <= '0;
          r_data_valid <= 1'b1;
          r_last       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TRACE_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (w_arm) begin
      r_csum <= '0;
    end else if (capture_done && !w_rewind_cmd &&
                 ((r_state == ST_FETCH1) || (r_state == ST_LATCH) || (r_state == ST_LATCH_LAST))) begin
      r_csum <= r_csum ^ mem_rd_data;
    end
  end
`endif

  assign mem_rd_en   = w_fetch;
  assign mem_rd_addr = w_fetch ? w_rd_ptr : '0;

  assign {regOut3, regOut2, regOut1, regOut0} = r_pkt0;
  assign {regOut7, regOut6, regOut5, regOut4} = r_pkt1;

  always_comb begin
    status                  = 8'h00;
    status[STAT_BUSY]       = (r_state != ST_IDLE);
    status[STAT_DATA_VALID] = r_data_valid;
    status[STAT_LAST]       = r_last;
    status[STAT_EMPTY]      = r_empty;
    status[STAT_OVERRUN]    = r_overrun;
    status[STAT_NOT_READY]  = ~capture_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_reader
// Brief    : Directed scoreboard bench for trace_reader (ADDR_WIDTH = 4).
// Revision : 1.0
// ============================================================================
module tb_trace_reader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    command;
  logic          command_strobe;
  logic          capture_done;
  logic [AW-1:0] capture_end_addr;
  logic [31:0]   capture_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data = 32'h0;
  logic [7:0]    regOut0, regOut1, regOut2, regOut3;
  logic [7:0]    regOut4, regOut5, regOut6, regOut7;
  logic [7:0]    status;

  trace_reader #(
    .SAMPLE_PACKET_WIDTH(32),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .command          (command),
    .command_strobe   (command_strobe),
    .capture_done     (capture_done),
    .capture_end_addr (capture_end_addr),
    .capture_count    (capture_count),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .regOut0          (regOut0),
    .regOut1          (regOut1),
    .regOut2          (regOut2),
    .regOut3          (regOut3),
    .regOut4          (regOut4),
    .regOut5          (regOut5),
    .regOut6          (regOut6),
    .regOut7          (regOut7),
    .status           (status)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  wire [63:0] regs = {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        empty;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          exp_addr[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_reads = 0;
  int          mon_a;
  int          m_rem, m_ptr;
  bit          m_armed;
  logic [63:0] last_data = 64'h0;
  exp_t        e_abort;
  int          reads_before;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_arm();
    m_rem   = (capture_count > 32'd16) ? 16 : int'(capture_count);
    m_ptr   = (int'(capture_end_addr) - m_rem + 1) & 15;
    m_armed = 1'b1;
  endfunction

  // Expected result of the next DATA command; queues the addresses it must read.
  task automatic m_next(output exp_t e);
    if (!m_armed) m_arm();
    e.data = 64'h0; e.last = 1'b0; e.empty = 1'b0; e.lat = 0;
    if (m_rem == 0) begin
      e.empty = 1'b1;
    end else if (m_rem == 1) begin
      e.data = {32'h0, mem[m_ptr]};
      e.last = 1'b1;
      e.lat  = 2;
      exp_addr.push_back(m_ptr);
      m_ptr = (m_ptr + 1) & 15;
      m_rem = m_rem - 1;
    end else begin
      e.data = {mem[(m_ptr + 1) & 15], mem[m_ptr]};
      e.last = (m_rem == 2);
      e.lat  = 3;
      exp_addr.push_back(m_ptr);
      exp_addr.push_back((m_ptr + 1) & 15);
      m_ptr = (m_ptr + 2) & 15;
      m_rem = m_rem - 2;
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_en) begin
      n_reads++;
      mon_a = (exp_addr.size() > 0) ? exp_addr.pop_front() : -1;
      check("rd_addr", {60'h0, mem_rd_addr}, 64'(mon_a));
    end
  end

  // Strobe is sampled at the next posedge (E0); returns at E0 + 1.
  task automatic strobe(input logic [7:0] c);
    @(negedge clk);
    command        = c;
    command_strobe = 1'b1;
    @(posedge clk);
    #1;
    command_strobe = 1'b0;
  endtask

  task automatic data_batch(input bit dbl);
    exp_t e;
    int   k;
    m_next(e);
    sb.push_back(e);
    @(negedge clk);
    command        = 8'h05;
    command_strobe = 1'b1;
    @(posedge clk);
    #1;
    k = 0;
    if (dbl) begin
      @(posedge clk);
      #1;
      k = 1;
    end
    command_strobe = 1'b0;
    if (!e.empty) check("busy", {63'h0, status[0]}, 64'h1);
    while (!status[1] && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    e = sb.pop_front();
    check("latency", 64'(k), 64'(e.lat));
    check("regout", regs, e.data);
    check("empty", {63'h0, status[3]}, {63'h0, e.empty});
    if (!e.empty) check("last", {63'h0, status[2]}, {63'h0, e.last});
    last_data = e.data;
  endtask

  task automatic rewind();
    strobe(8'h06);
    m_arm();
    check("rewind_valid", {63'h0, status[1]}, 64'h0);
    check("rewind_overrun", {63'h0, status[4]}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n          = 1'b0;
    capture_done     = 1'b0;
    command          = 8'h00;
    command_strobe   = 1'b0;
    capture_count    = 32'd5;
    capture_end_addr = 4'd2;
    m_armed          = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;

    repeat (2) @(negedge clk);
    check("rst_regs", regs, 64'h0);
    check("rst_status", {56'h0, status}, 64'h20);
    check("rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("rst_rd_addr", {60'h0, mem_rd_addr}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    capture_done = 1'b1;
    #1;
    check("ready_status", {56'h0, status}, 64'h00);

    // count 5, end 2: addrs 14,15 / 0,1 / 2 / empty
    repeat (4) data_batch(1'b0);

    // buffer overflowed: exactly 16 packets from addr 8
    capture_count    = 32'd40;
    capture_end_addr = 4'd7;
    rewind();
    reads_before = n_reads;
    repeat (9) data_batch(1'b0);
    check("reads_16", 64'(n_reads - reads_before), 64'd16);

    // DATA strobe one cycle into a batch
    capture_count    = 32'd5;
    capture_end_addr = 4'd2;
    rewind();
    data_batch(1'b1);
    check("overrun_set", {63'h0, status[4]}, 64'h1);
    rewind();
    data_batch(1'b0);

    // capture_done drops during FETCH1
    m_next(e_abort);
    strobe(8'h05);
    @(posedge clk);
    #1;
    capture_done = 1'b0;
    @(posedge clk);
    #1;
    check("drop_status", {56'h0, status}, 64'h20);
    check("drop_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("drop_regs_hold", regs, last_data);
    m_armed = 1'b0;
    @(negedge clk);
    capture_done = 1'b1;
    data_batch(1'b0);

    // asynchronous reset during LATCH
    m_next(e_abort);
    strobe(8'h05);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("latch_busy", {63'h0, status[0]}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_regs", regs, 64'h0);
    check("arst_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("arst_status", {56'h0, status}, 64'h00);
    m_armed = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // checksum command
    mem[0]           = 32'hA5A5_0001;
    mem[1]           = 32'h0F0F_0002;
    capture_count    = 32'd2;
    capture_end_addr = 4'd1;
    rewind();
    data_batch(1'b0);
    strobe(8'h07);
`ifdef TRACE_READER_CHECKSUM_EN
    check("csum_regs", regs, {32'h0, 32'hAAAA_0003});
    check("csum_valid", {63'h0, status[1]}, 64'h1);
`else
    check("csum_ignored_regs", regs, last_data);
    check("csum_ignored_status", {56'h0, status}, 64'h06);
`endif

    @(negedge clk);
    check("addr_queue_drained", 64'(exp_addr.size()), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
